// File: rtl/game_multibar_core.sv
// Multi-bar falling-hole game engine: bars, random holes, lives, post-hit invulnerability, score.
// Optional GAME_SPEEDUP_EN: bars advance on every Nth step_tick, N shrinking as bars wrap.
module game_multibar_core #(
  parameter int          NUM_BARS     = 2,
  parameter int          SCREEN_H     = 512,
  parameter int          COLS         = 16,
  parameter int          HOLE_W       = 3,
  parameter int          HIT_ROW      = 440,
  parameter int          LIVES_INIT   = 3,
  parameter int          INVULN_STEPS = 32,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          START_DIV    = 4,
  parameter int          SPEEDUP_BARS = 8,
  localparam int         POS_W        = $clog2(SCREEN_H),
  localparam int         COL_W        = $clog2(COLS),
  localparam int         LIV_W        = $clog2(LIVES_INIT + 1)
) (
  input  logic                      gameclk,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      step_tick,
  input  logic                      score_tick,
  input  logic [COL_W-1:0]          plrpos,
  output logic [NUM_BARS*POS_W-1:0] barpos,
  output logic [NUM_BARS*COL_W-1:0] holepos,
  output logic [LIV_W-1:0]          lives,
  output logic [15:0]               timealive,
  output logic                      game_over,
  output logic                      hit
);
  localparam int SPACING = SCREEN_H / NUM_BARS;
  localparam int INV_W   = $clog2(INVULN_STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic [1:0]       state;
  logic [POS_W-1:0] bar     [NUM_BARS];
  logic [POS_W-1:0] bar_nx  [NUM_BARS];
  logic [COL_W-1:0] hole    [NUM_BARS];
  logic [COL_W-1:0] hole_nx [NUM_BARS];
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nx;
  logic [INV_W-1:0] inv_cnt;
  logic [COL_W-1:0] hole_rand;
  logic             collide;
  logic             active;
  logic             reload;
  logic             adv;

  assign active    = (state == S_PLAY) || (state == S_HIT);
  assign reload    = start && !active;
  assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign hole_rand = COL_W'(lfsr % 16'(COLS - HOLE_W + 1));

  // Hole is only reloaded at row 0, so the current hole is the one seen at HIT_ROW.
  always_comb begin
    collide = 1'b0;
    for (int unsigned k = 0; k < NUM_BARS; k++) begin
      bar_nx[k]  = bar[k] + 1'b1;
      hole_nx[k] = hole[k];
      if (bar[k] == POS_W'(SCREEN_H - 1)) begin
        bar_nx[k]  = '0;
        hole_nx[k] = hole_rand;
      end
      if (bar_nx[k] == POS_W'(HIT_ROW) &&
          (int'(plrpos) < int'(hole[k]) || int'(plrpos) >= int'(hole[k]) + HOLE_W ||
           int'(plrpos) >= COLS))
        collide = 1'b1;
    end
  end

`ifdef GAME_SPEEDUP_EN
  localparam int DIV_W  = $clog2(START_DIV + 1);
  localparam int WRAP_W = $clog2(SPEEDUP_BARS + NUM_BARS + 1);

  logic [DIV_W-1:0]  div_n;
  logic [DIV_W-1:0]  div_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WRAP_W-1:0] wraps;
  logic [WRAP_W-1:0] wrap_sum;

  always_comb begin
    wraps = '0;
    for (int unsigned k = 0; k < NUM_BARS; k++)
      if (bar[k] == POS_W'(SCREEN_H - 1)) wraps = wraps + 1'b1;
  end

  assign wrap_sum = wrap_cnt + wraps;
  // >= rather than == so a divisor shrinking below the running count still fires.
  assign adv      = step_tick && (div_cnt + 1'b1 >= div_n);

  always_ff @(posedge gameclk) begin
    if (clr || reload) begin
      div_n    <= DIV_W'(START_DIV);
      div_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (active && step_tick) begin
      div_cnt <= adv ? '0 : div_cnt + 1'b1;
      if (adv) begin
        if (wrap_sum >= WRAP_W'(SPEEDUP_BARS)) begin
          wrap_cnt <= wrap_sum - WRAP_W'(SPEEDUP_BARS);
          if (div_n > DIV_W'(1)) div_n <= div_n - 1'b1;
        end else begin
          wrap_cnt <= wrap_sum;
        end
      end
    end
  end
`else
  assign adv = step_tick;
`endif

  always_ff @(posedge gameclk) begin
    if (clr) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      for (int unsigned k = 0; k < NUM_BARS; k++) begin
        bar[k]  <= POS_W'(k * SPACING);
        hole[k] <= '0;
      end
      lives     <= LIV_W'(LIVES_INIT);
      timealive <= '0;
      game_over <= 1'b0;
      hit       <= 1'b0;
      inv_cnt   <= '0;
    end else begin
      lfsr <= lfsr_nx;
      hit  <= 1'b0;
      if (reload) begin
        state     <= S_PLAY;
        for (int unsigned k = 0; k < NUM_BARS; k++) begin
          bar[k]  <= POS_W'(k * SPACING);
          hole[k] <= '0;
        end
        lives     <= LIV_W'(LIVES_INIT);
        timealive <= '0;
        game_over <= 1'b0;
        inv_cnt   <= '0;
      end else if (active) begin
        if (score_tick && timealive != '1) timealive <= timealive + 1'b1;
        if (adv) begin
          for (int unsigned k = 0; k < NUM_BARS; k++) begin
            bar[k]  <= bar_nx[k];
            hole[k] <= hole_nx[k];
          end
          if (state == S_HIT) begin
            inv_cnt <= inv_cnt - 1'b1;
            if (inv_cnt == INV_W'(1)) state <= S_PLAY;
          end else if (collide && lives != '0) begin
            lives <= lives - 1'b1;
            hit   <= 1'b1;
            if (lives == LIV_W'(1)) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state   <= S_HIT;
              inv_cnt <= INV_W'(INVULN_STEPS);
            end
          end
        end
      end
    end
  end

  always_comb begin
    barpos  = '0;
    holepos = '0;
    for (int unsigned k = 0; k < NUM_BARS; k++) begin
      barpos[k*POS_W +: POS_W]  = bar[k];
      holepos[k*COL_W +: COL_W] = hole[k];
    end
  end
endmodule

// File: tb/tb_game_multibar_core.sv
// Bench for game_multibar_core: directed phases plus random play against a behavioural game model.
module tb_game_multibar_core;
  localparam int          INV  = 300;
  localparam int          SH   = 512;
  localparam int          HR   = 440;
  localparam int          HW   = 3;
  localparam int          NCOL = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_IDLE = 0, M_PLAY = 1, M_IMM = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        step_tick = 1'b0;
  logic        score_tick = 1'b0;
  logic [3:0]  plrpos = '0;
  logic [17:0] barpos;
  logic [7:0]  holepos;
  logic [1:0]  lives;
  logic [15:0] timealive;
  logic        game_over;
  logic        hit;

  int total = 0;
  int bad = 0;
  bit saw_hit = 1'b0;

  int          m_pos  [2];
  int          m_hole [2];
  int          m_lives, m_score, m_mode, m_imm;
  bit          m_hit;
  logic [15:0] m_lfsr;

  game_multibar_core #(.INVULN_STEPS(INV)) dut (
    .gameclk(clk), .clr(clr), .start(start), .step_tick(step_tick),
    .score_tick(score_tick), .plrpos(plrpos), .barpos(barpos), .holepos(holepos),
    .lives(lives), .timealive(timealive), .game_over(game_over), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reload();
    m_pos[0] = 0;  m_pos[1] = SH / 2;
    m_hole[0] = 0; m_hole[1] = 0;
    m_lives = 3; m_score = 0; m_imm = 0; m_hit = 1'b0;
  endtask

  // One game-clock edge of the reference game, using the inputs currently driven.
  task automatic model_step();
    logic [15:0] nl;
    bit coll;
    int np;
    m_hit = 1'b0;
    if (clr) begin
      model_reload();
      m_lfsr = SEED;
      m_mode = M_IDLE;
      return;
    end
    nl = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (start) begin
        model_reload();
        m_mode = M_PLAY;
      end
    end else begin
      if (score_tick && m_score < 65535) m_score++;
      if (step_tick) begin
        coll = 1'b0;
        for (int k = 0; k < 2; k++) begin
          np = (m_pos[k] + 1) % SH;
          if (np == 0) m_hole[k] = int'(m_lfsr % 16'd14);
          m_pos[k] = np;
          if (np == HR && (int'(plrpos) < m_hole[k] || int'(plrpos) >= m_hole[k] + HW)) coll = 1'b1;
        end
        if (m_mode == M_IMM) begin
          m_imm++;
          if (m_imm == INV) m_mode = M_PLAY;
        end else if (coll) begin
          m_lives--;
          m_hit = 1'b1;
          if (m_lives == 0) m_mode = M_OVER;
          else begin
            m_mode = M_IMM;
            m_imm = 0;
          end
        end
      end
    end
    m_lfsr = nl;
  endtask

  task automatic check_model();
    chk("barpos", 32'(barpos), 32'(m_pos[1] * SH + m_pos[0]));
    chk("holepos", 32'(holepos), 32'(m_hole[1] * NCOL + m_hole[0]));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("timealive", 32'(timealive), 32'(m_score));
    chk("game_over", 32'(game_over), 32'(m_mode == M_OVER));
    chk("hit", 32'(hit), 32'(m_hit));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    if (hit === 1'b1) saw_hit = 1'b1;
  endtask

  // mode 0: stand inside the hole of the bar about to reach HR; mode 1: stand outside it.
  function automatic logic [3:0] pick_col(input int mode);
    int k = -1;
    for (int i = 0; i < 2; i++) if (m_pos[i] == HR - 1) k = i;
    if (mode == 0 && k >= 0) return 4'(m_hole[k] + int'($urandom_range(0, HW - 1)));
    if (mode == 1 && k >= 0) return 4'((m_hole[k] + HW + int'($urandom_range(0, NCOL - HW - 1))) % NCOL);
    return 4'($urandom_range(0, NCOL - 1));
  endfunction

  initial begin
    int snap_bar;
    int snap_score;

    // reset wins over start and ticks
    clr = 1'b1; start = 1'b1; step_tick = 1'b1; score_tick = 1'b1;
    cyc();
    clr = 1'b0; start = 1'b0;
    chk("rst_barpos", 32'(barpos), 32'(256 * 512));
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_time", 32'(timealive), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    repeat (5) cyc();
    chk("idle_bars_hold", 32'(barpos), 32'(256 * 512));
    chk("idle_time_hold", 32'(timealive), 32'd0);
    step_tick = 1'b0; score_tick = 1'b0;

    // long dodging game: no hits, score saturates
    start = 1'b1; cyc(); start = 1'b0;
    saw_hit = 1'b0;
    score_tick = 1'b1;
    for (int i = 0; i < 66000; i++) begin
      step_tick = ($urandom_range(0, 15) == 0);
      plrpos = pick_col(0);
      cyc();
    end
    chk("dodge_lives", 32'(lives), 32'd3);
    chk("dodge_no_hit", 32'(saw_hit), 32'd0);
    chk("score_sat", 32'(timealive), 32'hFFFF);

    // first crossing with player outside hole 0
    score_tick = 1'b0; step_tick = 1'b0;
    clr = 1'b1; cyc(); clr = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    plrpos = 4'd15; step_tick = 1'b1;
    for (int i = 0; i < 183; i++) begin
      score_tick = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("pre_hit_lives", 32'(lives), 32'd3);
    cyc();
    chk("hit_pulse", 32'(hit), 32'd1);
    chk("hit_lives", 32'(lives), 32'd2);
    repeat (INV) cyc();
    chk("immune_lives", 32'(lives), 32'd2);

    for (int i = 0; i < 2000 && m_mode != M_OVER; i++) begin
      plrpos = pick_col(1);
      score_tick = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);

    snap_bar = m_pos[1] * SH + m_pos[0];
    snap_score = m_score;
    step_tick = 1'b1; score_tick = 1'b1;
    repeat (100) cyc();
    chk("frozen_bars", 32'(barpos), 32'(snap_bar));
    chk("frozen_time", 32'(timealive), 32'(snap_score));

    // restart from OVER, take a hit, then clear mid-invulnerability
    step_tick = 1'b0; score_tick = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_barpos", 32'(barpos), 32'(256 * 512));
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_time", 32'(timealive), 32'd0);
    chk("restart_over", 32'(game_over), 32'd0);
    plrpos = 4'd15; step_tick = 1'b1; score_tick = 1'b1;
    repeat (184) cyc();
    chk("second_hit_lives", 32'(lives), 32'd2);
    repeat (10) cyc();
    clr = 1'b1; start = 1'b1; cyc();
    clr = 1'b0; start = 1'b0; step_tick = 1'b0; score_tick = 1'b0;
    chk("clr_hit_barpos", 32'(barpos), 32'(256 * 512));
    chk("clr_hit_hole", 32'(holepos), 32'd0);
    chk("clr_hit_lives", 32'(lives), 32'd3);
    chk("clr_hit_time", 32'(timealive), 32'd0);
    chk("clr_hit_flag", 32'(hit), 32'd0);

    // free-running random play
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      step_tick = 1'($urandom_range(0, 1));
      score_tick = 1'($urandom_range(0, 1));
      plrpos = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
